// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard.
//   FWD_*     : per-operand forward select driven to E (RF, W-stage result, M-stage result).
//   AGE_*     : pipeline stage of an in-flight register writer (E=1, M=2, W=3).
//   MUL_CNT_W : width of the multiply occupancy counter (MUL_LAT up to 8).
//   sb_entry_t: one scoreboard slot.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] AGE_E = 2'd1;
  localparam logic [1:0] AGE_M = 2'd2;
  localparam logic [1:0] AGE_W = 2'd3;

  localparam int unsigned MUL_CNT_W = 3;

  typedef struct packed {
    logic       busy;
    logic [1:0] age;
    logic       load;
  } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: tracks whether a register has an in-flight writer, the stage that
// writer is in, and whether it is a load.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   set_i   : a writer to this register enters E this cycle (wins over aging/retire)
//   load_i  : that writer is a load
//   hold_i  : E is stalled, freeze age
//   entry_o : current slot state
module sb_entry
  import hazard_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      set_i,
  input  logic      load_i,
  input  logic      hold_i,
  output sb_entry_t entry_o
);

  sb_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (set_i) begin
      entry_d.busy = 1'b1;
      entry_d.age  = AGE_E;
      entry_d.load = load_i;
    end else if (!hold_i && entry_q.busy) begin
      if (entry_q.age == AGE_W) begin
        entry_d = '0;
      end else begin
        entry_d.age = entry_q.age + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/hazard_sb.sv
// Hazard scoreboard for a 5-stage pipeline (F, D, E, M, W).
// Detects load-use hazards, multi-cycle multiply occupancy, PC-writing instructions and
// taken branches, and produces pipeline stall/flush controls plus registered forward selects.
//   clk, reset          : clock, synchronous active-low reset
//   issue_d             : valid instruction in D
//   src_d, src_used_d   : D source registers (RW bits each) and per-operand read mask
//   dst_d, wr_d         : D destination register and write enable
//   load_d, mul_d, pcwr_d : D instruction is a load / multiply / writes PC
//   branch_taken_e      : branch in E resolved taken
//   stall_f/d/e, flush_d/e : pipeline controls
//   fwd_e               : registered forward select per operand for the instruction in E
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int unsigned NREG    = 16,
  parameter int unsigned NSRC    = 3,
  parameter int unsigned MUL_LAT = 3,
  localparam int unsigned RW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_d,
  input  logic [NSRC*RW-1:0]  src_d,
  input  logic [NSRC-1:0]     src_used_d,
  input  logic [RW-1:0]       dst_d,
  input  logic                wr_d,
  input  logic                load_d,
  input  logic                mul_d,
  input  logic                pcwr_d,
  input  logic                branch_taken_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                flush_d,
  output logic                flush_e,
  output logic [NSRC*2-1:0]   fwd_e
);

  sb_entry_t sb [NREG];

  logic                 advance, mul_busy, branch_eff, load_use, pcwr_busy, stall_d_raw;
  logic [NSRC-1:0]      lu_src;
  logic [NSRC*2-1:0]    sel;
  logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [2:0]           pcwr_trk_q, pcwr_trk_d;  // [0]=E, [1]=M, [2]=W
  logic [NSRC*2-1:0]    fwd_q, fwd_d;

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    sb_entry u_entry (
      .clk_i   (clk),
      .rst_ni  (reset),
      .set_i   (advance && wr_d && (dst_d == RW'(r))),
      .load_i  (load_d),
      .hold_i  (mul_busy),
      .entry_o (sb[r])
    );
  end

  // Lookups use the registered scoreboard, so a same-cycle D write never affects its own
  // sources.
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    sb_entry_t src_ent;
    logic      hit;
    assign src_ent    = sb[src_d[s*RW +: RW]];
    assign hit        = src_used_d[s] && src_ent.busy;
    assign lu_src[s]  = hit && (src_ent.age == AGE_E) && src_ent.load;
    assign sel[s*2 +: 2] = !hit                    ? FWD_RF :
                           (src_ent.age == AGE_E)  ? FWD_M  :
                           (src_ent.age == AGE_M)  ? FWD_W  : FWD_RF;
  end

  assign mul_busy    = (mul_cnt_q != '0);
  // A branch cannot resolve while a multiply owns E; ignore it then.
  assign branch_eff  = branch_taken_e && !mul_busy;
  assign load_use    = issue_d && (|lu_src);
  assign pcwr_busy   = (issue_d && pcwr_d) || pcwr_trk_q[0] || pcwr_trk_q[1];
  assign stall_d_raw = (load_use || mul_busy) && !branch_eff;
  assign advance     = issue_d && !stall_d_raw && !branch_eff;

  always_comb begin
    mul_cnt_d  = mul_cnt_q;
    pcwr_trk_d = pcwr_trk_q;
    fwd_d      = fwd_q;
    if (mul_busy) begin
      mul_cnt_d = mul_cnt_q - 1'b1;
    end else begin
      if (advance && mul_d) begin
        mul_cnt_d = MUL_CNT_W'(MUL_LAT - 1);
      end
      pcwr_trk_d = {pcwr_trk_q[1:0], advance && pcwr_d};
      // Bubbles (flush or no advance) enter E with no forwarding.
      fwd_d      = advance ? sel : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mul_cnt_q  <= '0;
      pcwr_trk_q <= '0;
      fwd_q      <= '0;
    end else begin
      mul_cnt_q  <= mul_cnt_d;
      pcwr_trk_q <= pcwr_trk_d;
      fwd_q      <= fwd_d;
    end
  end

  // Controls are forced low while reset is asserted so an aborted multiply stops at once.
  assign stall_f = reset && (load_use || mul_busy || pcwr_busy);
  assign stall_d = reset && stall_d_raw;
  assign stall_e = reset && mul_busy;
  assign flush_d = reset && (pcwr_busy || pcwr_trk_q[2] || branch_eff);
  assign flush_e = reset && (load_use || branch_eff);
  assign fwd_e   = fwd_q;

endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;

  localparam int NREG    = 16;
  localparam int NSRC    = 3;
  localparam int MUL_LAT = 3;
  localparam int RW      = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               issue_d;
  logic [NSRC*RW-1:0] src_d;
  logic [NSRC-1:0]    src_used_d;
  logic [RW-1:0]      dst_d;
  logic               wr_d, load_d, mul_d, pcwr_d, branch_taken_e;
  logic               stall_f, stall_d, stall_e, flush_d, flush_e;
  logic [NSRC*2-1:0]  fwd_e;

  always #5 clk = ~clk;

  hazard_sb #(
    .NREG    (NREG),
    .NSRC    (NSRC),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_d        (issue_d),
    .src_d          (src_d),
    .src_used_d     (src_used_d),
    .dst_d          (dst_d),
    .wr_d           (wr_d),
    .load_d         (load_d),
    .mul_d          (mul_d),
    .pcwr_d         (pcwr_d),
    .branch_taken_e (branch_taken_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .fwd_e          (fwd_e)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: list of in-flight advanced instructions with their stage (1=E..3=W).
  typedef struct packed {
    logic [3:0] dst;
    logic       wr;
    logic       ld;
    logic       pc;
    logic [2:0] age;
  } rec_t;

  rec_t              fl[$];
  int                mul_left = 0;
  logic [NSRC*2-1:0] m_fwd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest in-flight writer of a register decides what a reader sees.
  function automatic void youngest(input int r, output int age, output bit ld);
    age = 0;
    ld  = 1'b0;
    foreach (fl[i]) begin
      if (fl[i].wr && int'(fl[i].dst) == r && (age == 0 || int'(fl[i].age) < age)) begin
        age = int'(fl[i].age);
        ld  = fl[i].ld;
      end
    end
  endfunction

  task automatic set_in(input bit iss, input bit [3:0] s0, input bit [3:0] s1,
                        input bit [3:0] s2, input bit [2:0] used, input bit [3:0] dst,
                        input bit wr, input bit ld, input bit mul, input bit pc, input bit bt);
    issue_d        = iss;
    src_d          = {s2, s1, s0};
    src_used_d     = used;
    dst_d          = dst;
    wr_d           = wr;
    load_d         = ld;
    mul_d          = mul;
    pcwr_d         = pc;
    branch_taken_e = bt;
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare every output with the model for the current inputs, then advance one clock.
  task automatic step();
    int                a;
    bit                l, lu, mb, bte, pcb, pcw, adv;
    bit                e_sf, e_sd, e_se, e_fd, e_fe;
    logic [NSRC*2-1:0] sel;
    rec_t              nr;
    lu  = 1'b0;
    sel = '0;
    for (int s = 0; s < NSRC; s++) begin
      youngest(int'(src_d[s*RW +: RW]), a, l);
      if (src_used_d[s]) begin
        if (a == 1 && l) lu = 1'b1;
        sel[2*s +: 2] = (a == 1) ? 2'b10 : (a == 2) ? 2'b01 : 2'b00;
      end
    end
    lu  = lu && issue_d;
    mb  = (mul_left > 0);
    bte = branch_taken_e && !mb;
    pcb = issue_d && pcwr_d;
    pcw = 1'b0;
    foreach (fl[i]) begin
      if (fl[i].pc && (fl[i].age == 1 || fl[i].age == 2)) pcb = 1'b1;
      if (fl[i].pc && fl[i].age == 3) pcw = 1'b1;
    end
    e_sf = lu || mb || pcb;
    e_sd = (lu || mb) && !bte;
    e_se = mb;
    e_fd = pcb || pcw || bte;
    e_fe = lu || bte;
    adv  = issue_d && !e_sd && !bte;
    if (!reset) {e_sf, e_sd, e_se, e_fd, e_fe} = '0;
    chk("stall_f", stall_f, e_sf);
    chk("stall_d", stall_d, e_sd);
    chk("stall_e", stall_e, e_se);
    chk("flush_d", flush_d, e_fd);
    chk("flush_e", flush_e, e_fe);
    chk("fwd_e", fwd_e, m_fwd);
    if (!reset) begin
      fl.delete();
      mul_left = 0;
      m_fwd    = '0;
    end else if (mb) begin
      mul_left--;
    end else begin
      for (int i = fl.size() - 1; i >= 0; i--) begin
        fl[i].age = fl[i].age + 3'd1;
        if (fl[i].age > 3) fl.delete(i);
      end
      if (adv) begin
        nr.dst = dst_d;
        nr.wr  = wr_d;
        nr.ld  = load_d;
        nr.pc  = pcwr_d;
        nr.age = 3'd1;
        fl.push_back(nr);
        if (mul_d) mul_left = MUL_LAT - 1;
      end
      m_fwd = adv ? sel : '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      idle();
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    step();
    step();
    reset = 1'b1;
    idle();
    chk("reset_stall_f", stall_f, 1'b0);
    chk("reset_fwd_e", fwd_e, '0);
    step();

    // Back-to-back ALU dependency: forward from M, no stall.
    set_in(1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0);
    step();
    set_in(1, 1, 0, 0, 3'b001, 2, 1, 0, 0, 0, 0);
    chk("alu_stall_d", stall_d, 1'b0);
    step();
    idle();
    chk("alu_fwd", fwd_e[1:0], 2'b10);
    step();
    drain();

    // Load-use: one bubble, then forward from W.
    set_in(1, 0, 0, 0, 3'b000, 3, 1, 1, 0, 0, 0);
    step();
    set_in(1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 0, 0);
    chk("lu_stall_f", stall_f, 1'b1);
    chk("lu_stall_d", stall_d, 1'b1);
    chk("lu_flush_e", flush_e, 1'b1);
    step();
    chk("lu_release", stall_d, 1'b0);
    step();
    idle();
    chk("lu_fwd", fwd_e[1:0], 2'b01);
    step();
    drain();

    // Multiply: E held MUL_LAT-1 cycles, then forward from M with no bubble.
    set_in(1, 0, 0, 0, 3'b000, 5, 1, 0, 1, 0, 0);
    step();
    set_in(1, 5, 0, 0, 3'b001, 6, 1, 0, 0, 0, 0);
    chk("mul_stall_e1", stall_e, 1'b1);
    step();
    chk("mul_stall_e2", stall_e, 1'b1);
    step();
    chk("mul_stall_e3", stall_e, 1'b0);
    chk("mul_no_bubble", flush_e, 1'b0);
    step();
    idle();
    chk("mul_fwd", fwd_e[1:0], 2'b10);
    step();
    drain();

    // Taken branch overrides a load-use stall; the flushed writer never reaches the board.
    set_in(1, 0, 0, 0, 3'b000, 3, 1, 1, 0, 0, 0);
    step();
    set_in(1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 0, 1);
    chk("br_flush_d", flush_d, 1'b1);
    chk("br_flush_e", flush_e, 1'b1);
    chk("br_stall_d", stall_d, 1'b0);
    step();
    set_in(1, 4, 0, 0, 3'b001, 7, 1, 0, 0, 0, 0);
    step();
    idle();
    chk("br_sb_clean", fwd_e[1:0], 2'b00);
    step();
    drain();

    // PC writer: stall_f for 3 cycles, flush_d for 4.
    set_in(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 5; c++) begin
      chk("pc_stall_f", stall_f, (c < 3) ? 1'b1 : 1'b0);
      chk("pc_flush_d", flush_d, (c < 4) ? 1'b1 : 1'b0);
      step();
      idle();
    end
    drain();

    // Reset during a multiply stall aborts it and empties the board.
    set_in(1, 0, 0, 0, 3'b000, 5, 1, 0, 1, 0, 0);
    step();
    set_in(1, 5, 0, 0, 3'b001, 6, 1, 0, 0, 0, 0);
    chk("rst_mul_busy", stall_e, 1'b1);
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
    set_in(1, 5, 0, 0, 3'b001, 6, 1, 0, 0, 0, 0);
    chk("rst_stall_e", stall_e, 1'b0);
    chk("rst_stall_f", stall_f, 1'b0);
    chk("rst_flush_d", flush_d, 1'b0);
    step();
    idle();
    chk("rst_sb_empty", fwd_e[1:0], 2'b00);
    step();
    drain();

    // Randomized traffic over a small register window to force collisions.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 120) != 0);
      set_in(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 3'($urandom), 4'($urandom_range(0, 3)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 9) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
